// File: rtl/flag_register.sv
// Derives Z/V/N flags from the EX-stage ALU result and provides committed and bypassed views to the ID-stage branch checker.
// Flags register 1 cycle after commit; flags_fwd and flag_hazard are combinational in the commit cycle.
// A stall or flush blocks the write; without bypass, a branch behind a pending flag writer raises flag_hazard.
module flag_register #(
    parameter int       DATA_W      = 16,
    parameter bit [2:0] RESET_FLAGS = 3'b000,
    parameter bit       USE_BYPASS  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [3:0]        ex_opcode,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_ovfl,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_is_branch,
    output logic [2:0]        flags_out,
    output logic [2:0]        flags_fwd,
    output logic              flag_hazard,
    output logic              halted
);

    // Opcodes that matter to the flag unit.
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t     state;
    logic [2:0] wr_mask;
    logic [2:0] new_flags;
    logic [2:0] merged_flags;
    logic       commit;

    // Per-opcode write mask, bit order {Z,V,N}.
    always_comb begin
        wr_mask = 3'b000;
        case (ex_opcode)
            OP_ADD, OP_SUB:                 wr_mask = 3'b111;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: wr_mask = 3'b100;
            default:                        wr_mask = 3'b000;
        endcase
    end

    // Raw flags from the ALU result and the masked merge with the held flags.
    always_comb begin
        new_flags    = {(ex_result == '0), ex_ovfl, ex_result[DATA_W-1]};
        merged_flags = (new_flags & wr_mask) | (flags_out & ~wr_mask);
    end

    // Flush beats stall; both block the write. Nothing retires once halted.
    assign commit = ex_valid & ~stall & ~flush & ~halted;

    // Branch view of the flags plus the no-bypass hazard check.
    always_comb begin
        flags_fwd   = flags_out;
        flag_hazard = 1'b0;
        if (rst) begin
            flags_fwd = RESET_FLAGS;
        end else begin
            if (USE_BYPASS && commit) begin
                flags_fwd = merged_flags;
            end
            // Hazard ignores stall, so a branch waiting behind a stalled writer keeps seeing it.
            if (!USE_BYPASS && !halted) begin
                flag_hazard = id_is_branch & ex_valid & ~flush & (wr_mask != 3'b000);
            end
        end
    end

    // Halt FSM, architectural flags and the registered halted output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RUN;
            halted    <= 1'b0;
            flags_out <= RESET_FLAGS;
        end else begin
            case (state)
                S_RUN: begin
                    if (commit) begin
                        flags_out <= merged_flags;
                        if (ex_opcode == OP_HLT) begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    // Only rst leaves HALT; the flags stay frozen.
                    state  <= S_HALT;
                    halted <= 1'b1;
                end
                default: begin
                    state  <= S_RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule
